// File: rtl/aes_pkg.sv
// Shared widths, feeder state encoding and the CBC chaining helper for the
// AES block feeder and its word packer.
package aes_pkg;

    localparam int BLOCK_W         = 128;
    localparam int WORD_W          = 32;
    localparam int WORDS_PER_BLOCK = 4;
    localparam int WORD_CNT_W      = $clog2(WORDS_PER_BLOCK);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } feeder_state_t;

    function automatic logic [BLOCK_W-1:0] chain_mix(input logic [BLOCK_W-1:0] block,
                                                     input logic [BLOCK_W-1:0] chain);
        return block ^ chain;
    endfunction

endpackage

// File: rtl/aes_word_packer.sv
// Collects four 32-bit words into one 128-bit block, word 0 in the MSBs.
// The block output already includes the word being accepted this cycle.
module aes_word_packer
    import aes_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  accept,
    input  logic [WORD_W-1:0]     data,
    output logic [WORD_CNT_W-1:0] word_cnt,
    output logic [BLOCK_W-1:0]    block,
    output logic                  block_done
);

    logic [WORD_CNT_W-1:0]     cnt_r;
    logic [BLOCK_W-WORD_W-1:0] shift_r;

    // Word counter wraps to 0 after the last word, ready for the next block
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r   <= {WORD_CNT_W{1'b0}};
            shift_r <= {(BLOCK_W-WORD_W){1'b0}};
        end else if (accept) begin
            cnt_r   <= cnt_r + WORD_CNT_W'(1);
            shift_r <= {shift_r[BLOCK_W-2*WORD_W-1:0], data};
        end else begin
            cnt_r   <= cnt_r;
            shift_r <= shift_r;
        end
    end

    assign word_cnt   = cnt_r;
    assign block      = {shift_r, data};
    assign block_done = accept && (cnt_r == WORD_CNT_W'(WORDS_PER_BLOCK - 1));

endmodule

// File: rtl/aes_block_feeder.sv
// Stream front-end for the Encrypt core: packs words, loads the core, waits
// out its latency and presents the ciphertext. AES_BLOCK_FEEDER_CBC_EN adds CBC.
module aes_block_feeder
    import aes_pkg::*;
#(
    parameter int LATENCY = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [WORD_W-1:0]  s_data,
    input  logic               s_first,
    input  logic [BLOCK_W-1:0] key,
    input  logic [BLOCK_W-1:0] iv,
    output logic               enc_enable,
    output logic [BLOCK_W-1:0] enc_plaintext,
    output logic [BLOCK_W-1:0] enc_key,
    input  logic [BLOCK_W-1:0] enc_ciphertext,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [BLOCK_W-1:0] m_data,
    output logic               busy
);

    localparam int CNT_W = $clog2(LATENCY);

    feeder_state_t         state_r;
    logic [CNT_W-1:0]      count_r;
    logic                  s_ready_r;
    logic                  enc_enable_r;
    logic                  busy_r;
    logic                  m_valid_r;
    logic [BLOCK_W-1:0]    enc_plaintext_r;
    logic [BLOCK_W-1:0]    enc_key_r;
    logic [BLOCK_W-1:0]    m_data_r;

    logic                  accept_s;
    logic [WORD_CNT_W-1:0] word_cnt_s;
    logic [BLOCK_W-1:0]    block_s;
    logic                  block_done_s;
    logic [BLOCK_W-1:0]    plain_s;
    logic                  capture_s;

    assign accept_s  = s_valid && s_ready_r;
    assign capture_s = (state_r == WAIT) && (count_r == {CNT_W{1'b0}});

    aes_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .accept     (accept_s),
        .data       (s_data),
        .word_cnt   (word_cnt_s),
        .block      (block_s),
        .block_done (block_done_s)
    );

`ifdef AES_BLOCK_FEEDER_CBC_EN
    logic [BLOCK_W-1:0] chain_r;

    assign plain_s = chain_mix(block_s, chain_r);

    // Chain starts from iv on a chain's first word, else follows the last result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chain_r <= {BLOCK_W{1'b0}};
        end else if (accept_s && (word_cnt_s == {WORD_CNT_W{1'b0}}) && s_first) begin
            chain_r <= iv;
        end else if (capture_s) begin
            chain_r <= enc_ciphertext;
        end else begin
            chain_r <= chain_r;
        end
    end
`else
    logic unused_s;

    assign plain_s  = block_s;
    assign unused_s = ^{iv, s_first, word_cnt_s};
`endif

    // Block sequencing FSM; every output is a register updated on transitions
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r         <= FILL;
            count_r         <= {CNT_W{1'b0}};
            s_ready_r       <= 1'b1;
            enc_enable_r    <= 1'b1;
            busy_r          <= 1'b0;
            m_valid_r       <= 1'b0;
            enc_plaintext_r <= {BLOCK_W{1'b0}};
            enc_key_r       <= {BLOCK_W{1'b0}};
            m_data_r        <= {BLOCK_W{1'b0}};
        end else begin
            case (state_r)
                FILL: begin
                    if (block_done_s) begin
                        enc_plaintext_r <= plain_s;
                        enc_key_r       <= key;
                        s_ready_r       <= 1'b0;
                        busy_r          <= 1'b1;
                        state_r         <= LOAD;
                    end
                end
                LOAD: begin
                    // Enable drops here so the core starts its rounds next cycle
                    enc_enable_r <= 1'b0;
                    count_r      <= CNT_W'(LATENCY - 1);
                    state_r      <= WAIT;
                end
                WAIT: begin
                    if (capture_s) begin
                        m_data_r  <= enc_ciphertext;
                        m_valid_r <= 1'b1;
                        state_r   <= OUT;
                    end else begin
                        count_r <= count_r - CNT_W'(1);
                    end
                end
                OUT: begin
                    if (m_ready) begin
                        m_valid_r    <= 1'b0;
                        s_ready_r    <= 1'b1;
                        enc_enable_r <= 1'b1;
                        busy_r       <= 1'b0;
                        state_r      <= FILL;
                    end
                end
                default: begin
                    state_r      <= FILL;
                    s_ready_r    <= 1'b1;
                    enc_enable_r <= 1'b1;
                    busy_r       <= 1'b0;
                    m_valid_r    <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready       = s_ready_r;
    assign enc_enable    = enc_enable_r;
    assign busy          = busy_r;
    assign m_valid       = m_valid_r;
    assign enc_plaintext = enc_plaintext_r;
    assign enc_key       = enc_key_r;
    assign m_data        = m_data_r;

endmodule

// File: tb/tb_aes_block_feeder.sv
// Self-checking bench for aes_block_feeder: a behavioural AES-128 core stands in
// for Encrypt, and a word-level reference model predicts every output block.
module tb_aes_block_feeder;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam int           LAT    = 11;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [31:0]  s_data = 32'h0;
    logic         s_first = 1'b0;
    logic [127:0] key = 128'h0;
    logic [127:0] iv = 128'h0;
    logic         enc_enable;
    logic [127:0] enc_plaintext;
    logic [127:0] enc_key;
    logic [127:0] enc_ciphertext;
    logic         m_valid;
    logic         m_ready = 1'b1;
    logic [127:0] m_data;
    logic         busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic mr_rand = 1'b0;

    logic [7:0] sbox_t [0:255];

    // stand-in Encrypt core state
    logic [127:0] core_pt = 128'h0;
    logic [127:0] core_key = 128'h0;
    logic [127:0] core_res = 128'h0;
    int           core_cnt = 15;

    // reference model state
    logic [31:0]  blk_m [0:3];
    int           nw = 0;
    logic [127:0] q [$];
    logic [127:0] exp_pt = 128'h0;
    logic [127:0] exp_key = 128'h0;
    bit           pend_load = 1'b0;
    int           load_cyc = -1;
    bit           prev_valid = 1'b0;
    bit           hs_prev = 1'b0;
`ifdef AES_BLOCK_FEEDER_CBC_EN
    logic [127:0] chain_m = 128'h0;
`endif

    aes_block_feeder dut (
        .clk            (clk),
        .reset          (reset),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .s_first        (s_first),
        .key            (key),
        .iv             (iv),
        .enc_enable     (enc_enable),
        .enc_plaintext  (enc_plaintext),
        .enc_key        (enc_key),
        .enc_ciphertext (enc_ciphertext),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] kk);
        logic [7:0] w [0:175];
        logic [7:0] s [0:15];
        logic [7:0] t [0:15];
        logic [7:0] rc, t0, t1, t2, t3, tmp, a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            w[i] = kk[127-8*i -: 8];
            s[i] = pt[127-8*i -: 8] ^ w[i];
        end
        rc = 8'h01;
        for (int i = 16; i < 176; i += 4) begin
            t0 = w[i-4]; t1 = w[i-3]; t2 = w[i-2]; t3 = w[i-1];
            if (i % 16 == 0) begin
                tmp = t0;
                t0 = sbox_t[t1] ^ rc; t1 = sbox_t[t2]; t2 = sbox_t[t3]; t3 = sbox_t[tmp];
                rc = xtime(rc);
            end
            w[i] = w[i-16] ^ t0; w[i+1] = w[i-15] ^ t1;
            w[i+2] = w[i-14] ^ t2; w[i+3] = w[i-13] ^ t3;
        end
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++) t[rr+4*c] = s[rr+4*((c+rr)%4)];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (r < 10) begin
                    s[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
                    s[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*r+i];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // Encrypt stand-in: enable holds the round counter at 0; result is only right from round 10
    always @(posedge clk) begin
        if (enc_enable) begin
            core_pt  <= enc_plaintext;
            core_key <= enc_key;
            core_cnt <= 0;
        end else begin
            if (core_cnt == 9) core_res <= aes_enc(core_pt, core_key);
            if (core_cnt < 15) core_cnt <= core_cnt + 1;
        end
    end

    assign enc_ciphertext = (core_cnt >= 10) ? core_res : ~core_res;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Per-cycle observation at the falling edge: protocol checks plus the reference model
    task automatic observe();
        logic [127:0] pt;
        logic [127:0] e;
        cyc++;
        if (!reset) begin
            nw = 0;
            q.delete();
            pend_load = 1'b0;
            load_cyc = -1;
            prev_valid = 1'b0;
            hs_prev = 1'b0;
`ifdef AES_BLOCK_FEEDER_CBC_EN
            chain_m = 128'h0;
`endif
        end else begin
            if (hs_prev) check("fill_after_handshake", {127'h0, s_ready}, 128'h1);
            if (busy && enc_enable) begin
                check("load_after_word3", {127'h0, pend_load}, 128'h1);
                check("load_plaintext", enc_plaintext, exp_pt);
                check("load_key", enc_key, exp_key);
                pend_load = 1'b0;
                load_cyc = cyc;
            end
            if (m_valid && !prev_valid) check("valid_latency", 128'(cyc - load_cyc), 128'(LAT + 1));
            if (m_valid) begin
                check("out_s_ready_low", {127'h0, s_ready}, 128'h0);
                check("out_enable_low", {127'h0, enc_enable}, 128'h0);
                if (q.size() == 0) begin
                    check("spurious_valid", {127'h0, m_valid}, 128'h0);
                end else begin
                    check("out_data", m_data, q[0]);
                    if (m_ready) e = q.pop_front();
                end
            end
            if (s_valid && s_ready) begin
`ifdef AES_BLOCK_FEEDER_CBC_EN
                if (nw == 0 && s_first) chain_m = iv;
`endif
                blk_m[nw] = s_data;
                nw++;
                if (nw == 4) begin
                    pt = {blk_m[0], blk_m[1], blk_m[2], blk_m[3]};
`ifdef AES_BLOCK_FEEDER_CBC_EN
                    pt = pt ^ chain_m;
`endif
                    e = aes_enc(pt, key);
                    q.push_back(e);
`ifdef AES_BLOCK_FEEDER_CBC_EN
                    chain_m = e;
`endif
                    exp_pt = pt;
                    exp_key = key;
                    pend_load = 1'b1;
                    nw = 0;
                end
            end
            prev_valid = m_valid;
            hs_prev = m_valid && m_ready;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        if (mr_rand) m_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_block(input logic [127:0] blk, input logic [127:0] k,
                              input logic [127:0] ivv, input logic first,
                              input int g0, input int g1, input int g2, input int g3);
        int g [4];
        int n;
        g[0] = g0; g[1] = g1; g[2] = g2; g[3] = g3;
        key = k;
        iv = ivv;
        for (int w = 0; w < 4; w++) begin
            s_valid = 1'b0;
            repeat (g[w]) tick();
            s_valid = 1'b1;
            s_data = blk[127-32*w -: 32];
            s_first = (w == 0) ? first : ~first;
            if (w > 0) iv = rand128();
            n = 0;
            while (!s_ready && n < 300) begin
                tick();
                n++;
            end
            if (n >= 300) check("accept_timeout", {127'h0, s_ready}, 128'h1);
            tick();
            if (w < 3) check("no_early_load", {127'h0, busy}, 128'h0);
            else       check("load_entered", {127'h0, busy}, 128'h1);
        end
        s_valid = 1'b0;
        s_first = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!m_valid && n < 100) begin
            tick();
            n++;
        end
        check("valid_timeout", {127'h0, m_valid}, 128'h1);
    endtask

    initial begin
        logic [7:0] inv;
        logic       seen;
        for (int i = 0; i < 256; i++) begin
            inv = 8'h00;
            for (int j = 1; j < 256; j++)
                if (i != 0 && gmul(8'(i), 8'(j)) == 8'h01) inv = 8'(j);
            sbox_t[i] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                            ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end

        // reset values, while held and just after release
        repeat (2) tick();
        check("rst_s_ready", {127'h0, s_ready}, 128'h1);
        check("rst_enable", {127'h0, enc_enable}, 128'h1);
        check("rst_m_valid", {127'h0, m_valid}, 128'h0);
        check("rst_busy", {127'h0, busy}, 128'h0);
        check("rst_plaintext", enc_plaintext, 128'h0);
        check("rst_key", enc_key, 128'h0);
        check("rst_m_data", m_data, 128'h0);
        reset = 1'b1;
        tick();
        check("idle_s_ready", {127'h0, s_ready}, 128'h1);
        check("idle_busy", {127'h0, busy}, 128'h0);

        // FIPS-197 C.1, back to back
        send_block(C1_PT, C1_KEY, 128'h0, 1'b1, 0, 0, 0, 0);
        wait_valid();
        check("c1_result", m_data, C1_CT);
        tick();

        // backpressure with ignored input words during OUT
        m_ready = 1'b0;
        send_block(C1_PT, C1_KEY, 128'h0, 1'b1, 0, 0, 0, 0);
        wait_valid();
        s_valid = 1'b1;
        s_data = $urandom;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {127'h0, m_valid}, 128'h1);
            check("bp_data", m_data, C1_CT);
            check("bp_s_ready", {127'h0, s_ready}, 128'h0);
            check("bp_enable", {127'h0, enc_enable}, 128'h0);
            tick();
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        tick();
        check("bp_fill_reentered", {127'h0, s_ready}, 128'h1);

        // bubbles between words
        send_block(C1_PT, C1_KEY, 128'h0, 1'b1, 0, 2, 0, 1);
        wait_valid();
        check("bubble_result", m_data, C1_CT);
        tick();

        // reset in WAIT cycle 5
        send_block(rand128(), rand128(), rand128(), 1'b1, 0, 0, 0, 0);
        repeat (5) tick();
        reset = 1'b0;
        #1;
        check("rstwait_m_valid", {127'h0, m_valid}, 128'h0);
        check("rstwait_s_ready", {127'h0, s_ready}, 128'h1);
        check("rstwait_busy", {127'h0, busy}, 128'h0);
        repeat (2) tick();
        reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (m_valid) seen = 1'b1;
            tick();
        end
        check("rstwait_no_valid", {127'h0, seen}, 128'h0);
        send_block(C1_PT, C1_KEY, 128'h0, 1'b1, 0, 0, 0, 0);
        wait_valid();
        check("rstwait_next_result", m_data, C1_CT);
        tick();

`ifdef AES_BLOCK_FEEDER_CBC_EN
        // SP800-38A F.2.1, first two blocks
        send_block(128'h6bc1bee22e409f96e93d7e117393172a, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                   128'h000102030405060708090a0b0c0d0e0f, 1'b1, 0, 0, 0, 0);
        wait_valid();
        check("cbc_block1", m_data, 128'h7649abac8119b246cee98e9b12e9197d);
        tick();
        send_block(128'hae2d8a571e03ac9c9eb76fac45af8e51, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                   rand128(), 1'b0, 0, 0, 0, 0);
        wait_valid();
        check("cbc_block2", m_data, 128'h5086cb9b507219ee95db113a917678b2);
        tick();
`endif

        // randomized traffic; key changes while the block is in flight
        mr_rand = 1'b1;
        for (int b = 0; b < 12; b++) begin
            send_block(rand128(), rand128(), rand128(), 1'($urandom_range(0, 1)),
                       $urandom_range(0, 2), $urandom_range(0, 2),
                       $urandom_range(0, 2), $urandom_range(0, 2));
            key = rand128();
        end
        for (int n = 0; n < 200 && q.size() != 0; n++) tick();
        check("drain", 128'(q.size()), 128'h0);
        mr_rand = 1'b0;
        m_ready = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_block_feeder.md
# aes_block_feeder

Stream front-end for the `Encrypt` core. It packs 32-bit input words into a 128-bit block and drives the core's `enable`, `plaintext` and `key` inputs. It then waits out the core's fixed round latency, captures `ciphertext` and presents it on a valid/ready output port. It sits between the host word stream and `Encrypt`, and is instantiated next to it in the top level.

## Interface
Parameters:
- `LATENCY`, default 11: cycles spent in WAIT before capturing `ciphertext`. Legal range is ≥ 11; raise it if key expansion is slower.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low; low = reset.
- `s_valid`  in  1  input word valid.
- `s_ready`  out  1  input word accepted when high with `s_valid`.
- `s_data`  in  32  plaintext word; word k maps to block bits [32k:32k+31], bit 0 = MSB.
- `s_first`  in  1  sampled with word 0; marks the first block of a CBC chain.
- `key`  in  128  cipher key, sampled when word 3 is accepted.
- `iv`  in  128  CBC initial vector, sampled when word 0 with `s_first` = 1 is accepted.
- `enc_enable`  out  1  to `Encrypt.enable`.
- `enc_plaintext`  out  128  to `Encrypt.plaintext`, registered.
- `enc_key`  out  128  to `Encrypt.key`, registered.
- `enc_ciphertext`  in  128  from `Encrypt.ciphertext`.
- `m_valid`  out  1  result valid.
- `m_ready`  in  1  result consumed.
- `m_data`  out  128  ciphertext block, registered.
- `busy`  out  1  high in LOAD, WAIT and OUT.

## Operation
- FSM states: FILL → LOAD → WAIT → OUT → FILL.
- **FILL**
  - `s_ready` = 1; a 2-bit word counter advances on each accepted word.
  - When word 3 is accepted: the assembled block (CBC-adjusted, see Configuration) goes to `enc_plaintext`, `key` goes to `enc_key`, and the FSM moves to LOAD.
- **LOAD**
  - Lasts exactly 1 cycle; `s_ready` = 0.
  - `enc_enable` stays 1 for this cycle, so `Encrypt` latches the final plaintext and key.
- **WAIT**
  - `enc_enable` = 0; the countdown loads `LATENCY`-1 on entry and decrements each edge.
  - On the edge where the count is 0: `enc_ciphertext` goes to `m_data`, and the FSM moves to OUT.
- **OUT**
  - `m_valid` = 1 and `enc_enable` = 0, so the core holds its result.
  - When `m_valid` && `m_ready`: the FSM returns to FILL with the word counter at 0.
- `enc_enable` = 1 throughout FILL and LOAD, which holds the core's stage counter at 0.
- Input words arriving while `s_ready` = 0 are ignored and not consumed.
- `s_first` and `iv` are ignored on words 1–3.
- Changes to `key` during LOAD, WAIT or OUT have no effect until the next block's word 3.

## Timing
- Reset values:
  - state FILL; `s_ready` 1; `enc_enable` 1.
  - `enc_plaintext`, `enc_key`, `m_data` and the chain register all 0.
  - `m_valid` 0; `busy` 0; both counters 0.
- If the LOAD cycle is n:
  - WAIT occupies cycles n+1 .. n+LATENCY.
  - `m_valid` rises in cycle n+LATENCY+1.
  - With default `LATENCY`, `m_valid` rises 12 cycles after LOAD.
- Minimum block period is 4 + 1 + LATENCY + 1 cycles, with `m_ready` held high and words back to back.
- Gaps in `s_valid` stretch FILL only; the counter holds its value across gaps.
- `m_ready` low in OUT: `m_data` and `m_valid` stay stable, and `s_ready` stays 0, for any number of cycles.
- Reset asserted in any state: reset values apply immediately (asynchronously). The partial block and the chain are discarded, and no `m_valid` pulse is produced.

## Configuration
- `AES_BLOCK_FEEDER_CBC_EN` defined:
  - `enc_plaintext` = assembled block XOR chain.
  - Chain = `iv` if word 0 of the block had `s_first` = 1; otherwise chain = the previous block's `m_data`.
  - The chain register updates on the capture edge.
  - If the first block after reset has `s_first` = 0, it is XORed with 0.
- Macro undefined:
  - `enc_plaintext` = assembled block (ECB).
  - `iv` and `s_first` are ignored, and no chain register exists.

## Structure
- Shared package `aes_pkg`:
  - `BLOCK_W` = 128, `WORD_W` = 32, `WORDS_PER_BLOCK` = 4.
  - The FSM state enum `feeder_state_t` (FILL, LOAD, WAIT, OUT).
- One sub-module, `aes_word_packer`: word counter, 4×32 shift/assemble register, and a `block_done` strobe.
- FSM, countdown, CBC XOR and output register stay in the top of `aes_block_feeder`.

## Test plan
- **FIPS-197 C.1, ECB.**
  - Stimulus: key 000102030405060708090a0b0c0d0e0f; words 00112233, 44556677, 8899aabb, ccddeeff.
  - Required: `m_data` = 69c4e0d86a7b0430d8cdb78070b4c55a; `m_valid` rises exactly 12 cycles after LOAD.
- **Backpressure.**
  - Stimulus: hold `m_ready` = 0 for 5 cycles in OUT.
  - Required: `m_data` stable, `s_ready` = 0, `enc_enable` = 0 throughout; FILL re-entered on the cycle after the handshake.
- **Bubbles.**
  - Stimulus: `s_valid` toggles 1, 0, 0, 1 across the four words.
  - Required: same ciphertext as the C.1 test; LOAD occurs only after the 4th accepted word.
- **Reset mid-WAIT.**
  - Stimulus: pull `reset` low in WAIT cycle 5.
  - Required: `m_valid` stays 0, `s_ready` = 1 after release; the next block gives the correct C.1 result.
- **CBC, macro defined, SP800-38A F.2.1.**
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, iv 000102030405060708090a0b0c0d0e0f.
  - P1 6bc1bee22e409f96e93d7e117393172a with `s_first` = 1 → 7649abac8119b246cee98e9b12e9197d.
  - P2 ae2d8a571e03ac9c9eb76fac45af8e51 with `s_first` = 0 → 5086cb9b507219ee95db113a917678b2.
- **Ignored inputs in LOAD/WAIT/OUT.**
  - Stimulus: `s_valid` high with `s_ready` = 0 in LOAD/WAIT/OUT, and `key` changed during WAIT.
  - Required: the word is not consumed; the current result is unaffected.
